// File: rtl/jk_bank_controller_if.sv
// Command channel of the JK bank controller: one command per valid/ready handshake.
interface jk_bank_controller_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [N-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_len;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_controller.sv
// Sequences j/k drive for a bank of N JK flip-flops: clear/set/toggle/load in one
// cycle, or up/down counting for a programmed number of cycles using q feedback.
module jk_bank_controller #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    jk_bank_controller_if.slave     cmd,
    input  logic                    abort,
    input  logic [N-1:0]            q,
    output logic [N-1:0]            j,
    output logic [N-1:0]            k,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       op_r;
    logic [N-1:0]     data_r;
    logic [N-1:0]     up_pat;
    logic [N-1:0]     dn_pat;
    logic             up_c;
    logic             dn_c;
    logic             is_count_op;

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign is_count_op   = (cmd.cmd_op == OP_UP) || (cmd.cmd_op == OP_DOWN);

    // Captured command payload; only meaningful outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cmd.cmd_valid) begin
            op_r   <= cmd.cmd_op;
            data_r <= cmd.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (is_count_op && cmd.cmd_len != '0) begin
                            state     <= COUNT;
                            remaining <= cmd.cmd_len;
                        end else begin
                            state <= APPLY;
                        end
                    end
                end
                APPLY: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    err   <= (op_r == OP_ILLEGAL);
                end
                COUNT: begin
                    if (abort || remaining == CNT_W'(1)) begin
                        state     <= IDLE;
                        remaining <= '0;
                        done      <= 1'b1;
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    remaining <= '0;
                end
            endcase
        end
    end

    // Ripple-carry toggle patterns: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_pat = '0;
        dn_pat = '0;
        up_c   = 1'b1;
        dn_c   = 1'b1;
        for (int i = 0; i < N; i++) begin
            up_pat[i] = up_c;
            dn_pat[i] = dn_c;
            up_c      = up_c & q[i];
            dn_c      = dn_c & ~q[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        case (state)
            APPLY: begin
                case (op_r)
                    OP_CLEAR:  k = '1;
                    OP_SET:    j = '1;
                    OP_TOGGLE: begin
                        j = data_r;
                        k = data_r;
                    end
                    OP_LOAD: begin
                        j = data_r;
                        k = ~data_r;
                    end
                    default: begin
                        j = '0;
                        k = '0;
                    end
                endcase
            end
            COUNT: begin
                if (!abort) begin
                    j = (op_r == OP_DOWN) ? dn_pat : up_pat;
                    k = j;
                end
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_jk_bank_controller.sv
// Directed bench for jk_bank_controller driving a behavioural 4-bit JK bank model.
module tb_jk_bank_controller;
    localparam int N     = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;

    logic         clk;
    logic         reset;
    logic         abort;
    logic [N-1:0] q;
    logic [N-1:0] j;
    logic [N-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    int n_assert;
    int n_fail;

    jk_bank_controller_if #(.N(N), .CNT_W(CNT_W)) cmd_if ();

    jk_bank_controller #(.N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .abort (abort),
        .q     (q),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    // JK bank: active-high reset driven from the inverted active-low reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= (j & ~q) | (~k & q);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in the current IDLE cycle; returns in the cycle after the handshake.
    task automatic hs(input logic [2:0] op, input logic [N-1:0] data, input logic [CNT_W-1:0] len);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_len   = len;
        tick();
        cmd_if.cmd_valid = 1'b0;
        #1;
    endtask

    task automatic load_q(input logic [N-1:0] v);
        hs(OP_LOAD, v, '0);
        tick();
        tick();
    endtask

    logic [N-1:0] exp_up[5];
    logic [N-1:0] exp_dn[3];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_up = '{4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011};
        exp_dn = '{4'b0000, 4'b1111, 4'b1110};
        reset            = 1'b0;
        abort            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_len   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", cmd_if.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_j", j, 0);
        chk("rst_k", k, 0);
        reset = 1'b1;
        tick();

        // LOAD 1010
        hs(OP_LOAD, 4'b1010, '0);
        chk("load_j", j, 4'b1010);
        chk("load_k", k, 4'b0101);
        chk("load_busy", busy, 1);
        chk("load_ready", cmd_if.cmd_ready, 0);
        chk("load_done_early", done, 0);
        tick();
        chk("load_q", q, 4'b1010);
        chk("load_done", done, 1);
        chk("load_err", err, 0);
        chk("load_ready_after", cmd_if.cmd_ready, 1);
        tick();
        chk("load_done_pulse", done, 0);

        // COUNT_UP len=5 from 1110, wrapping
        load_q(4'b1110);
        hs(OP_UP, '0, 8'd5);
        chk("up_j0", j, 4'b0001);
        chk("up_k0", k, 4'b0001);
        chk("up_busy0", busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("up_q%0d", i), q, exp_up[i]);
            if (i < 4) begin
                chk($sformatf("up_busy%0d", i), busy, 1);
                chk($sformatf("up_nodone%0d", i), done, 0);
            end
        end
        chk("up_done", done, 1);
        chk("up_idle", busy, 0);
        chk("up_j_end", j, 0);
        chk("up_k_end", k, 0);
        tick();

        // COUNT_DOWN len=3 from 0001, wrapping
        load_q(4'b0001);
        hs(OP_DOWN, '0, 8'd3);
        chk("dn_j0", j, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("dn_q%0d", i), q, exp_dn[i]);
        end
        chk("dn_done", done, 1);
        tick();

        // COUNT_UP len=0 behaves as NOP
        hs(OP_UP, '0, 8'd0);
        chk("len0_busy", busy, 1);
        chk("len0_j", j, 0);
        chk("len0_k", k, 0);
        tick();
        chk("len0_done", done, 1);
        chk("len0_q", q, 4'b1110);
        tick();

        // TOGGLE / CLEAR / SET / illegal
        load_q(4'b1010);
        hs(OP_TOGGLE, 4'b0110, '0);
        chk("tog_j", j, 4'b0110);
        chk("tog_k", k, 4'b0110);
        tick();
        chk("tog_q", q, 4'b1100);
        chk("tog_done", done, 1);
        tick();
        hs(OP_CLEAR, 4'b0101, '0);
        chk("clr_j", j, 4'b0000);
        chk("clr_k", k, 4'b1111);
        tick();
        chk("clr_q", q, 4'b0000);
        tick();
        hs(OP_SET, '0, '0);
        chk("set_j", j, 4'b1111);
        chk("set_k", k, 4'b0000);
        tick();
        chk("set_q", q, 4'b1111);
        chk("set_err", err, 0);
        tick();
        hs(OP_ILL, 4'b0101, '0);
        chk("ill_j", j, 0);
        chk("ill_k", k, 0);
        tick();
        chk("ill_q", q, 4'b1111);
        chk("ill_done", done, 1);
        chk("ill_err", err, 1);
        tick();
        chk("ill_err_pulse", err, 0);

        // Abort in the 3rd COUNT cycle; abort during the IDLE handshake is ignored
        load_q(4'b0000);
        abort = 1'b1;
        hs(OP_UP, '0, 8'd10);
        abort = 1'b0;
        #1;
        chk("ab_accepted", busy, 1);
        chk("ab_q0", q, 4'b0000);
        tick();
        chk("ab_q1", q, 4'b0001);
        tick();
        chk("ab_q2", q, 4'b0010);
        abort = 1'b1;
        #1;
        chk("ab_j", j, 0);
        chk("ab_k", k, 0);
        chk("ab_busy", busy, 1);
        tick();
        abort = 1'b0;
        chk("ab_q_hold", q, 4'b0010);
        chk("ab_done", done, 1);
        chk("ab_idle", busy, 0);
        tick();
        chk("ab_done_pulse", done, 0);

        // Reset mid-count with cmd_valid held high
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_UP;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_len   = 8'd10;
        tick();
        cmd_if.cmd_op   = OP_LOAD;
        cmd_if.cmd_data = 4'b0101;
        cmd_if.cmd_len  = '0;
        tick();
        tick();
        chk("rc_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("rc_j", j, 0);
        chk("rc_k", k, 0);
        chk("rc_busy_low", busy, 0);
        chk("rc_done", done, 0);
        chk("rc_ready", cmd_if.cmd_ready, 1);
        chk("rc_q", q, 0);
        tick();
        chk("rc_hold_busy", busy, 0);
        chk("rc_hold_done", done, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rc_rel_done", done, 0);
        tick();
        chk("rc_accept_busy", busy, 1);
        chk("rc_accept_j", j, 4'b0101);
        chk("rc_accept_k", k, 4'b1010);
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("rc_q_load", q, 4'b0101);
        chk("rc_done_load", done, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_bank_controller.md
# jk_bank_controller

Sequencer for a bank of N JK flip-flops in the register/counter datapath. It accepts one command at a time over a valid/ready handshake and drives the bank's per-bit j/k inputs for one or more cycles: clear, set, toggle-by-mask, parallel load, or up/down counting for a programmed number of cycles. It reads the bank's q outputs back to compute counting patterns. The bank flops use an active-high reset, so at top level they are reset from the inverted `reset` of this block.

## Interface

- `N`, 4: bank width in bits, legal 1..16.
- `CNT_W`, 8: width of the count-length field.

- `clk`  in  1  rising-edge clock, shared with the bank.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command. High only in IDLE.
- `cmd_op`  in  3  opcode (see Operation).
- `cmd_data`  in  N  load value or toggle mask.
- `cmd_len`  in  CNT_W  number of count cycles for count ops.
- `abort`  in  1  stops an in-progress count.
- `q`  in  N  feedback from the bank's q outputs.
- `j`  out  N  bank j inputs.
- `k`  out  N  bank k inputs.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse when an illegal opcode completes.

## Operation

- **Opcodes**
  - 000 NOP: j=k=0.
  - 001 CLEAR: j=0, k=all ones.
  - 010 SET: j=all ones, k=0.
  - 011 TOGGLE: j=k=data.
  - 100 LOAD: j=data, k=~data.
  - 101 COUNT_UP.
  - 110 COUNT_DOWN.
  - 111 illegal: treated as NOP, and `err` pulses together with `done`.
- **States**
  - IDLE: `cmd_ready`=1, j=k=0.
  - IDLE → APPLY on handshake (`cmd_valid` and `cmd_ready` at a rising edge) for opcodes 000–100, 111, and for count ops with `cmd_len`=0.
  - IDLE → COUNT on handshake for count ops with `cmd_len`≥1.
  - On handshake, op, data and len are captured into internal registers. `cmd_*` inputs are ignored outside IDLE.
  - APPLY: lasts exactly one cycle. j/k are driven from the captured op/data, then the state returns to IDLE.
  - COUNT: the remaining counter is loaded with len and decrements every COUNT cycle. Exit to IDLE after the cycle in which remaining==1.
- **Count patterns** (combinational from `q`)
  - COUNT_UP: j[i]=k[i]=&q[i-1:0]; bit 0 always toggles.
  - COUNT_DOWN: j[i]=k[i]=&~q[i-1:0].
  - Wrap-around is natural modulo 2^N: all-ones+1=0 and 0−1=all-ones. There is no saturation.
- **Abort**
  - Sampled only in COUNT.
  - If `abort`=1 in a COUNT cycle: j=k=0 in that cycle, the state goes to IDLE at the next edge, and `done` pulses.
  - Abort is ignored in IDLE and APPLY.
- **done / err**
  - `done` is registered, high for the first IDLE cycle after APPLY or COUNT.
  - `err` is high in the same cycle as `done`, only for opcode 111.
- **Reset**
  - Asserting `reset` (low) at any time, including mid-count, forces IDLE immediately: j=k=0, busy=0, done=0, err=0, remaining=0, cmd_ready=1.
  - A command interrupted by reset produces no `done`.

## Timing

- **Output classes**
  - `j`/`k`: combinational from state, the captured registers and `q`. No internal register stage.
  - `busy`, `cmd_ready`: decoded from state.
  - `done`, `err`: registered.
- **Single-cycle op timeline**
  - Edge E0: handshake.
  - Cycle after E0: APPLY, j/k valid.
  - Edge E1: the bank updates.
  - Cycle after E1: IDLE, `done`=1, `cmd_ready`=1.
  - A new command can be accepted at E2, so throughput is one single-cycle op per 2 cycles.
- **Count op timeline**
  - L COUNT cycles; the bank changes at each of the L edges.
  - `done` is high in the cycle after the last COUNT cycle. Latency from handshake to `done` is L+1 cycles.
- **len=0**: same timeline as NOP; `done` 2 cycles after the handshake, bank unchanged.
- **Back-to-back**: `cmd_valid` held high through a busy period is accepted at the first IDLE edge. This is the same cycle in which `done` is high.

## Test plan

Values below use N=4.

1. Reset, then LOAD data=1010 → in the APPLY cycle j=1010, k=0101; q=1010 afterwards; `done` is 1 exactly 2 cycles after the handshake, and `err`=0.
2. From q=1110, COUNT_UP len=5 → q steps through 1111, 0000, 0001, 0010, 0011 (wrap covered); `done` in cycle 6 after the handshake; j=k=0 afterwards.
3. From q=0001, COUNT_DOWN len=3 → q steps through 0000, 1111, 1110. Then COUNT_UP len=0 → q unchanged and `done` after 2 cycles.
4. Sequence on q=1010: TOGGLE 0110 → q=1100; CLEAR → q=0000; SET → q=1111; opcode 111 → q unchanged, with `done` and `err` both pulsing in the same cycle.
5. From q=0000, COUNT_UP len=10 with `abort`=1 during the 3rd COUNT cycle → q=0010, j=k=0 in that cycle, and `done` in the next cycle. `abort` pulses in IDLE have no effect.
6. Drive `reset` low mid-COUNT with `cmd_valid` held high → j=k=0 and busy=0 immediately with no `done`; after release the held command is accepted at the first edge.
